led_display_scanner: RTL and testbench
======================================

Name: led_display_scanner

Overview:
- Downstream consumer of the CPU's 16-bit `led_out` bus; drives a 4-digit, common-anode, multiplexed seven-segment display in hexadecimal.
- Captures the CPU value only at frame boundaries, so a digit never shows a mix of old and new data (no tearing).
- Scans the digits with a programmable refresh divider and supports leading-zero blanking and a freeze/hold mode.
- Sits between `cpu` and the board pins in the top level.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot. Must be >= 1. Divider width is $clog2(REFRESH_DIV), minimum 1.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- led_in  input  16  CPU output value (driven by `cpu.led_out`).
- freeze  input  1  1 = hold the displayed value; frame-boundary loads are suppressed.
- blank_lz  input  1  1 = blank leading zero digits.
- an  output  4  digit anodes, active-low, one-hot; an[k] selects nibble k.
- seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.
- update_strobe  output  1  one-cycle pulse when a frame-boundary load changes the captured value.

Behaviour:
- State registers:
  - div_cnt: 0..REFRESH_DIV-1.
  - dig: 0..3.
  - cap[15:0]: captured value.
  - blz_q: sampled blank_lz.
  - frz_q: freeze, registered every cycle.
  - update_strobe: registered.
- Reset values: div_cnt=0, dig=0, cap=0, blz_q=0, frz_q=0, update_strobe=0. Resulting outputs: an=4'b1110, seg=7'b1000000, dp=1.
- tick = (div_cnt == REFRESH_DIV-1).
  - On tick: div_cnt<=0 and dig<=dig+1, wrapping 3->0.
  - Otherwise: div_cnt<=div_cnt+1.
- Frame boundary = tick && dig==3. On that edge:
  - If frz_q==0: cap<=led_in and blz_q<=blank_lz.
  - update_strobe<=1 only if frz_q==0 and led_in != cap (the old value); otherwise 0.
  - On all other edges, update_strobe<=0.
- While frz_q==1, cap and blz_q hold. The display keeps scanning.
- Outputs:
  - an, seg and dp are decoded only from registered state (dig, cap, blz_q, frz_q). There is no combinational path from led_in, blank_lz or freeze.
  - Outputs change on the same edge as dig.
- Nibble for slot k: cap[4k+3:4k].
- Hex encoding of seg (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking:
  - When blz_q==1, slot k (k in 1..3) is blanked if nibbles k..3 are all zero.
  - Blanked slot: an=4'b1111, seg=7'b1111111.
  - Slot 0 is never blanked, so value 0 shows a single "0".
- dp=0 only during slot 0 while frz_q==1; otherwise dp=1.
- REFRESH_DIV=1: tick every cycle; each slot lasts one cycle; a frame is 4 cycles.
- First load after reset: at the edge ending cycle 4*REFRESH_DIV. The display shows 0 until then.
- Reset asserted mid-frame: all state and outputs return to reset values asynchronously. Scanning restarts at slot 0 with a full slot length after deassertion.
- freeze changing in the same cycle as a frame boundary: the boundary uses frz_q, i.e. the value registered on the previous edge.

Test Plan:
1. Reset: assert reset between clock edges -> an=1110, seg=1000000, dp=1, update_strobe=0 with no clock edge; state holds while reset is high.
2. REFRESH_DIV=4, led_in=16'h1A3F, blank_lz=0, freeze=0:
   - update_strobe is high for exactly 1 cycle after edge 16.
   - Each slot lasts 4 cycles: an=1110/seg=0001110, then an=1101/seg=0110000, then an=1011/seg=0001000, then an=0111/seg=1111001; repeats.
3. Tearing: after 2, change led_in to 16'h0000 during slot 1 -> slots 1..3 still show 3, A, 1; the next frame shows all "0"; one update_strobe at that boundary.
4. Blanking:
   - blank_lz=1, led_in=16'h0042 -> slots 0,1 show 2,4; slots 2,3 have an=1111, seg=1111111.
   - led_in=16'h0000 -> only slot 0 lit, showing 1000000.
5. Freeze: freeze=1 before a boundary, led_in=16'hBEEF -> cap unchanged, no strobe, dp=0 in slot 0 only. Release freeze -> the next boundary loads BEEF (slot 0 seg=0001110), strobe 1 cycle.
6. Unchanged value: led_in held at 16'h1234 across three frame boundaries -> strobe only at the first; REFRESH_DIV=1 run shows the same scan with 1-cycle slots.

Source files
------------

// File: rtl/led_display_scanner.sv
`timescale 1ns/1ps
// led_display_scanner
//   Drives a 4-digit common-anode multiplexed seven-segment display with the
//   16-bit CPU value in hex. The value is captured only at frame boundaries,
//   so a frame never shows a mix of old and new digits.
//
// Ports
//   clock         : system clock, rising edge
//   reset         : asynchronous, active-high
//   led_in[15:0]  : CPU output value
//   freeze        : 1 = hold captured value (frame loads suppressed)
//   blank_lz      : 1 = blank leading zero digits (sampled at frame boundary)
//   an[3:0]       : digit anodes, active-low, an[k] selects nibble k
//   seg[6:0]      : segments, active-low, {g,f,e,d,c,b,a}
//   dp            : decimal point, active-low (lit in slot 0 while frozen)
//   update_strobe : one-cycle pulse when a frame load changes the value
module led_display_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] led_in,
  input  logic        freeze,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        update_strobe
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   cap_q, cap_d;
  logic          blz_q, blz_d;
  logic          frz_q;
  logic          strobe_q, strobe_d;

  logic tick, frame_end;

  assign tick      = (div_cnt_q == DIV_LAST);
  assign frame_end = tick && (dig_q == 2'd3);

  always_comb begin
    div_cnt_d = div_cnt_q + CW'(1);
    dig_d     = dig_q;
    cap_d     = cap_q;
    blz_d     = blz_q;
    strobe_d  = 1'b0;
    if (tick) begin
      div_cnt_d = '0;
      dig_d     = dig_q + 2'd1;
    end
    // Loads use the freeze value registered on the previous edge.
    if (frame_end && !frz_q) begin
      cap_d    = led_in;
      blz_d    = blank_lz;
      strobe_d = (led_in != cap_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      dig_q     <= '0;
      cap_q     <= '0;
      blz_q     <= 1'b0;
      frz_q     <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_q     <= dig_d;
      cap_q     <= cap_d;
      blz_q     <= blz_d;
      frz_q     <= freeze;
      strobe_q  <= strobe_d;
    end
  end

  assign update_strobe = strobe_q;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // zk: nibbles k..3 are all zero, so slot k is a leading zero.
  logic z1, z2, z3;
  assign z3 = (cap_q[15:12] == 4'h0);
  assign z2 = z3 && (cap_q[11:8] == 4'h0);
  assign z1 = z2 && (cap_q[7:4] == 4'h0);

  logic [3:0] nib;
  logic       blank;

  always_comb begin
    nib   = cap_q[3:0];
    blank = 1'b0;
    an    = 4'b1110;
    case (dig_q)
      2'd0: begin nib = cap_q[3:0];   an = 4'b1110; end
      2'd1: begin nib = cap_q[7:4];   an = 4'b1101; blank = blz_q && z1; end
      2'd2: begin nib = cap_q[11:8];  an = 4'b1011; blank = blz_q && z2; end
      default: begin nib = cap_q[15:12]; an = 4'b0111; blank = blz_q && z3; end
    endcase
    seg = hex7(nib);
    if (blank) begin
      an  = 4'b1111;
      seg = 7'b1111111;
    end
    dp = !((dig_q == 2'd0) && frz_q);
  end

endmodule

// File: tb/tb_led_display_scanner.sv
`timescale 1ns/1ps
module tb_led_display_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        reset1 = 1'b1;
  logic [15:0] led_in = '0;
  logic        freeze = 1'b0;
  logic        blank_lz = 1'b0;

  logic [3:0] an, an1;
  logic [6:0] seg, seg1;
  logic       dp, dp1, stb, stb1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, SA = 7'b0001000,
                         SB = 7'b0000011, SE = 7'b0000110, SF = 7'b0001110,
                         SX = 7'b1111111;

  led_display_scanner #(.REFRESH_DIV(4)) dut (
    .clock(clock), .reset(reset), .led_in(led_in), .freeze(freeze),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .update_strobe(stb)
  );

  led_display_scanner #(.REFRESH_DIV(1)) dut1 (
    .clock(clock), .reset(reset1), .led_in(led_in), .freeze(freeze),
    .blank_lz(blank_lz), .an(an1), .seg(seg1), .dp(dp1), .update_strobe(stb1)
  );

  always #5 clock = ~clock;

  task automatic adv(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [12:0] obs,
                       input logic [3:0] an_e, input logic [6:0] seg_e,
                       input logic dp_e, input logic st_e);
    logic [12:0] exp_v;
    exp_v = {an_e, seg_e, dp_e, st_e};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $display("FAIL %s: {an,seg,dp,strobe} got %b expected %b", tag, obs, exp_v);
      $error("miscompare %s got %b expected %b", tag, obs, exp_v);
    end
  endtask

  initial begin
    // 1. asynchronous reset, no clock edge yet
    #2 reset = 1'b1;
    #1 check("rst_async", {an, seg, dp, stb}, 4'b1110, S0, 1'b1, 1'b0);
    adv(3);
    check("rst_hold", {an, seg, dp, stb}, 4'b1110, S0, 1'b1, 1'b0);

    // 2. basic scan, DIV=4, 1A3F
    led_in = 16'h1A3F;
    reset  = 1'b0;
    adv(1);   // e1
    check("pre_load_s0", {an, seg, dp, stb}, 4'b1110, S0, 1'b1, 1'b0);
    adv(14);  // e15
    check("pre_load_s3", {an, seg, dp, stb}, 4'b0111, S0, 1'b1, 1'b0);
    adv(1);   // e16
    check("load_strobe", {an, seg, dp, stb}, 4'b1110, SF, 1'b1, 1'b1);
    adv(1);   // e17
    check("strobe_1cyc", {an, seg, dp, stb}, 4'b1110, SF, 1'b1, 1'b0);
    adv(3);   // e20
    check("scan_s1", {an, seg, dp, stb}, 4'b1101, S3, 1'b1, 1'b0);
    adv(4);   // e24
    check("scan_s2", {an, seg, dp, stb}, 4'b1011, SA, 1'b1, 1'b0);
    adv(4);   // e28
    check("scan_s3", {an, seg, dp, stb}, 4'b0111, S1, 1'b1, 1'b0);
    adv(4);   // e32
    check("same_val_nostb", {an, seg, dp, stb}, 4'b1110, SF, 1'b1, 1'b0);

    // 3. tearing: change during slot 1
    adv(4);   // e36
    led_in = 16'h0000;
    check("tear_s1", {an, seg, dp, stb}, 4'b1101, S3, 1'b1, 1'b0);
    adv(4);   // e40
    check("tear_s2", {an, seg, dp, stb}, 4'b1011, SA, 1'b1, 1'b0);
    adv(4);   // e44
    check("tear_s3", {an, seg, dp, stb}, 4'b0111, S1, 1'b1, 1'b0);
    adv(4);   // e48
    check("zero_load", {an, seg, dp, stb}, 4'b1110, S0, 1'b1, 1'b1);
    adv(4);   // e52
    check("zero_s1_unblanked", {an, seg, dp, stb}, 4'b1101, S0, 1'b1, 1'b0);

    // 4. leading-zero blanking
    blank_lz = 1'b1;
    led_in   = 16'h0042;
    adv(4);   // e56
    check("blz_not_yet", {an, seg, dp, stb}, 4'b1011, S0, 1'b1, 1'b0);
    adv(8);   // e64
    check("blz_s0", {an, seg, dp, stb}, 4'b1110, S2, 1'b1, 1'b1);
    adv(4);   // e68
    check("blz_s1", {an, seg, dp, stb}, 4'b1101, S4, 1'b1, 1'b0);
    adv(4);   // e72
    check("blz_s2", {an, seg, dp, stb}, 4'b1111, SX, 1'b1, 1'b0);
    adv(4);   // e76
    check("blz_s3", {an, seg, dp, stb}, 4'b1111, SX, 1'b1, 1'b0);
    led_in = 16'h0000;
    adv(4);   // e80
    check("blz_zero_s0", {an, seg, dp, stb}, 4'b1110, S0, 1'b1, 1'b1);
    adv(4);   // e84
    check("blz_zero_s1", {an, seg, dp, stb}, 4'b1111, SX, 1'b1, 1'b0);

    // 5. freeze
    freeze   = 1'b1;
    led_in   = 16'hBEEF;
    blank_lz = 1'b0;
    adv(8);   // e92
    check("frz_s3", {an, seg, dp, stb}, 4'b1111, SX, 1'b1, 1'b0);
    adv(4);   // e96
    check("frz_hold_dp", {an, seg, dp, stb}, 4'b1110, S0, 1'b0, 1'b0);
    adv(4);   // e100
    check("frz_s1_dp_off", {an, seg, dp, stb}, 4'b1111, SX, 1'b1, 1'b0);
    freeze = 1'b0;
    adv(8);   // e108
    check("unfrz_s3", {an, seg, dp, stb}, 4'b1111, SX, 1'b1, 1'b0);
    adv(4);   // e112
    check("unfrz_load", {an, seg, dp, stb}, 4'b1110, SF, 1'b1, 1'b1);
    adv(1);   // e113
    check("unfrz_stb_off", {an, seg, dp, stb}, 4'b1110, SF, 1'b1, 1'b0);
    adv(3);   // e116
    check("beef_s1", {an, seg, dp, stb}, 4'b1101, SE, 1'b1, 1'b0);
    adv(4);   // e120
    check("beef_s2", {an, seg, dp, stb}, 4'b1011, SE, 1'b1, 1'b0);
    adv(4);   // e124
    check("beef_s3", {an, seg, dp, stb}, 4'b0111, SB, 1'b1, 1'b0);

    // mid-frame reset between edges
    adv(2);
    #2 reset = 1'b1;
    #1 check("rst_mid", {an, seg, dp, stb}, 4'b1110, S0, 1'b1, 1'b0);
    adv(1);
    check("rst_mid_hold", {an, seg, dp, stb}, 4'b1110, S0, 1'b1, 1'b0);

    // 6. unchanged value, both dividers
    led_in = 16'h1234;
    reset  = 1'b0;
    reset1 = 1'b0;
    adv(1);   // e1
    check("d1_s1_pre", {an1, seg1, dp1, stb1}, 4'b1101, S0, 1'b1, 1'b0);
    check("d4_restart", {an, seg, dp, stb}, 4'b1110, S0, 1'b1, 1'b0);
    adv(2);   // e3
    check("d1_s3_pre", {an1, seg1, dp1, stb1}, 4'b0111, S0, 1'b1, 1'b0);
    check("d4_full_slot", {an, seg, dp, stb}, 4'b1110, S0, 1'b1, 1'b0);
    adv(1);   // e4
    check("d4_slot1", {an, seg, dp, stb}, 4'b1101, S0, 1'b1, 1'b0);
    check("d1_load", {an1, seg1, dp1, stb1}, 4'b1110, S4, 1'b1, 1'b1);
    adv(1);   // e5
    check("d1_s1", {an1, seg1, dp1, stb1}, 4'b1101, S3, 1'b1, 1'b0);
    adv(1);   // e6
    check("d1_s2", {an1, seg1, dp1, stb1}, 4'b1011, S2, 1'b1, 1'b0);
    adv(1);   // e7
    check("d1_s3", {an1, seg1, dp1, stb1}, 4'b0111, S1, 1'b1, 1'b0);
    adv(1);   // e8
    check("d1_same_nostb", {an1, seg1, dp1, stb1}, 4'b1110, S4, 1'b1, 1'b0);
    adv(8);   // e16
    check("d4_1234_load", {an, seg, dp, stb}, 4'b1110, S4, 1'b1, 1'b1);
    adv(1);   // e17
    check("d4_1234_off", {an, seg, dp, stb}, 4'b1110, S4, 1'b1, 1'b0);
    adv(15);  // e32
    check("d4_1234_2nd", {an, seg, dp, stb}, 4'b1110, S4, 1'b1, 1'b0);
    adv(16);  // e48
    check("d4_1234_3rd", {an, seg, dp, stb}, 4'b1110, S4, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
